// File: rtl/lcd_ctrl.sv
// lcd_ctrl: 16x2 character LCD sequencer, 4-bit bus mode.
// Runs the power-up init and configuration nibbles, then writes requested
// bytes (command or character) as high/low nibble pairs with timed E strobes.
module lcd_ctrl #(
    parameter int T_PWRUP   = 750000,
    parameter int T_INIT1   = 205000,
    parameter int T_INIT2   = 5000,
    parameter int T_SETUP   = 2,
    parameter int T_E_HIGH  = 12,
    parameter int T_NIB_GAP = 50,
    parameter int T_CMD     = 2000,
    parameter int T_CLEAR   = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       busy,
    output logic       sf_e,
    output logic       e,
    output logic       rs,
    output logic       rw,
    output logic [3:0] D
);

    function automatic int maxi(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int TMAX = maxi(maxi(maxi(T_PWRUP, T_INIT1), maxi(T_INIT2, T_SETUP)),
                               maxi(maxi(T_E_HIGH, T_NIB_GAP), maxi(T_CMD, T_CLEAR)));
    localparam int CW   = $clog2(TMAX + 1);

    // Steps 0..3 are the bare init nibbles, 4..11 the config bytes split hi/lo.
    function automatic logic [3:0] init_nibble(input logic [3:0] st);
        case (st)
            4'd0, 4'd1, 4'd2: return 4'h3;
            4'd3, 4'd4:       return 4'h2;
            4'd5:             return 4'h8;
            4'd7:             return 4'h6;
            4'd9:             return 4'hC;
            4'd11:            return 4'h1;
            default:          return 4'h0;
        endcase
    endfunction

    function automatic int init_wait(input logic [3:0] st);
        if (st == 4'd0)
            return T_INIT1;
        else if (st < 4'd4)
            return T_INIT2;
        else if (st[0] == 1'b0)
            return T_NIB_GAP;
        else if (st == 4'd11)
            return T_CLEAR;
        else
            return T_CMD;
    endfunction

    // Counter load for a phase of n cycles (counts down to zero inclusive).
    function automatic logic [CW-1:0] ld(input int n);
        return CW'(n - 1);
    endfunction

    typedef enum logic [2:0] {
        S_PWRUP,
        S_SETUP,
        S_EHIGH,
        S_HOLD,
        S_WAIT,
        S_IDLE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    step, step_nxt;
    logic          nib_lo, nib_lo_nxt;
    logic          load_nib;
    logic          accept;
    logic          init_fin;
    logic [3:0]    nib_val;
    logic          rs_val;
    logic          cur_rs;
    logic [7:0]    cur_byte;
    logic          is_clear;
    int            wait_len;

    assign sf_e     = 1'b1;
    assign rw       = 1'b0;
    assign is_clear = !cur_rs && (cur_byte == 8'h01 || cur_byte == 8'h02 || cur_byte == 8'h03);

    // Next-state, counter reload and nibble selection for the sequencer.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        step_nxt   = step;
        nib_lo_nxt = nib_lo;
        load_nib   = 1'b0;
        accept     = 1'b0;
        init_fin   = 1'b0;
        nib_val    = 4'h0;
        rs_val     = 1'b0;
        wait_len   = T_CMD;

        if (!init_done)
            wait_len = init_wait(step);
        else if (!nib_lo)
            wait_len = T_NIB_GAP;
        else if (is_clear)
            wait_len = T_CLEAR;
        else
            wait_len = T_CMD;

        case (state)
            S_PWRUP: begin
                if (cnt == '0) begin
                    state_nxt = S_SETUP;
                    cnt_nxt   = ld(T_SETUP);
                    load_nib  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_nxt = S_EHIGH;
                    cnt_nxt   = ld(T_E_HIGH);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_EHIGH: begin
                if (cnt == '0) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_HOLD: begin
                state_nxt = S_WAIT;
                cnt_nxt   = ld(wait_len);
            end
            S_WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (!init_done) begin
                    if (step == 4'd11) begin
                        state_nxt = S_IDLE;
                        init_fin  = 1'b1;
                    end else begin
                        step_nxt  = step + 4'd1;
                        state_nxt = S_SETUP;
                        cnt_nxt   = ld(T_SETUP);
                        load_nib  = 1'b1;
                    end
                end else if (!nib_lo) begin
                    nib_lo_nxt = 1'b1;
                    state_nxt  = S_SETUP;
                    cnt_nxt    = ld(T_SETUP);
                    load_nib   = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    accept     = 1'b1;
                    nib_lo_nxt = 1'b0;
                    state_nxt  = S_SETUP;
                    cnt_nxt    = ld(T_SETUP);
                    load_nib   = 1'b1;
                end
            end
            default: state_nxt = S_PWRUP;
        endcase

        if (!init_done) begin
            nib_val = init_nibble(step_nxt);
            rs_val  = 1'b0;
        end else if (accept) begin
            nib_val = req_data[7:4];
            rs_val  = req_rs;
        end else begin
            nib_val = cur_byte[3:0];
            rs_val  = cur_rs;
        end
    end

    // Control state and registered LCD pins; reset drops e immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_PWRUP;
            cnt       <= ld(T_PWRUP);
            step      <= 4'd0;
            nib_lo    <= 1'b0;
            e         <= 1'b0;
            rs        <= 1'b0;
            D         <= 4'h0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            step      <= step_nxt;
            nib_lo    <= nib_lo_nxt;
            e         <= (state_nxt == S_EHIGH);
            req_ready <= (state_nxt == S_IDLE);
            busy      <= (state_nxt != S_IDLE);
            init_done <= init_done | init_fin;
            if (load_nib) begin
                rs <= rs_val;
                D  <= nib_val;
            end
        end
    end

    // Captured request byte; only meaningful after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            cur_rs   <= req_rs;
            cur_byte <= req_data;
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed bench for lcd_ctrl with shortened timing parameters.
module tb_lcd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, init_done, busy, sf_e, e, rs, rw;
    logic [3:0] D;

    lcd_ctrl #(
        .T_PWRUP(100), .T_INIT1(40), .T_INIT2(10), .T_SETUP(2),
        .T_E_HIGH(4), .T_NIB_GAP(3), .T_CMD(8), .T_CLEAR(20)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_rs(req_rs),
        .req_data(req_data), .req_ready(req_ready), .init_done(init_done),
        .busy(busy), .sf_e(sf_e), .e(e), .rs(rs), .rw(rw), .D(D)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Cycle count since reset release.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Pulse monitor sampled on the falling edge.
    logic [3:0] rise_d[$];
    logic       rise_rs[$];
    int         widths[$];
    int         first_rise = -1;
    int         stab_err = 0;
    int         pin_err = 0;
    int         hi_len = 0;
    logic       e_prev = 1'b0;
    logic [3:0] d_at_rise = 4'h0;
    logic       rs_at_rise = 1'b0;

    always @(negedge clk) begin
        if (e && !e_prev) begin
            rise_d.push_back(D);
            rise_rs.push_back(rs);
            d_at_rise  = D;
            rs_at_rise = rs;
            hi_len     = 1;
            if (first_rise < 0) first_rise = cyc;
        end else if (e) begin
            hi_len++;
        end
        if (!e && e_prev) widths.push_back(hi_len);
        if (e && (D !== d_at_rise || rs !== rs_at_rise)) stab_err++;
        if (rw !== 1'b0 || sf_e !== 1'b1) pin_err++;
        e_prev = e;
    end

    task automatic clear_mon();
        rise_d.delete();
        rise_rs.delete();
        widths.delete();
    endtask

    task automatic wait_init();
        int n = 0;
        while (!init_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("init_timeout", {31'd0, init_done}, 32'd1);
    endtask

    // Present a byte, wait for acceptance, optionally drop valid, then
    // return how many sampled cycles req_ready stayed low.
    task automatic send(input logic r, input logic [7:0] d, input logic drop, output int low);
        int n = 0;
        req_valid = 1'b1;
        req_rs    = r;
        req_data  = d;
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (drop) req_valid = 1'b0;
        low = 0;
        while (!req_ready && low < 200) begin
            low++;
            @(negedge clk);
        end
    endtask

    task automatic check_init_pulses(input string tag);
        logic [3:0] exp_d [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
        chk({tag, "_npulse"}, rise_d.size(), 12);
        if (rise_d.size() == 12 && widths.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                chk($sformatf("%s_d%0d", tag, i), {28'd0, rise_d[i]}, {28'd0, exp_d[i]});
                chk($sformatf("%s_rs%0d", tag, i), {31'd0, rise_rs[i]}, 32'd0);
                chk($sformatf("%s_w%0d", tag, i), widths[i], 4);
            end
        end
    endtask

    task automatic check_pair(input string tag, input logic [3:0] hi, input logic [3:0] lo, input logic r);
        chk({tag, "_npulse"}, rise_d.size(), 2);
        if (rise_d.size() == 2 && widths.size() == 2) begin
            chk({tag, "_hi"}, {28'd0, rise_d[0]}, {28'd0, hi});
            chk({tag, "_lo"}, {28'd0, rise_d[1]}, {28'd0, lo});
            chk({tag, "_rs"}, {30'd0, rise_rs[0], rise_rs[1]}, {30'd0, r, r});
            chk({tag, "_w"}, widths[0] + widths[1], 8);
        end
    endtask

    initial begin
        int low, low2, gap;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_e", {31'd0, e}, 32'd0);
        chk("rst_rs_d", {27'd0, rs, D}, 32'd0);
        chk("rst_ready_done", {30'd0, req_ready, init_done}, 32'd0);
        chk("rst_busy_sfe_rw", {29'd0, busy, sf_e, rw}, 32'b110);

        // Power-up init and configuration.
        rst = 1'b0;
        wait_init();
        chk("first_rise_cyc", first_rise, 102);
        chk("init_done_cyc", cyc, 310);
        chk("init_ready", {30'd0, req_ready, busy}, 32'b10);
        check_init_pulses("init");
        clear_mon();

        // Character 'A'.
        send(1'b1, 8'h41, 1'b1, low);
        chk("char_low", low, 25);
        repeat (2) @(negedge clk);
        check_pair("char", 4'h4, 4'h1, 1'b1);
        clear_mon();

        // Clear display command.
        send(1'b0, 8'h01, 1'b1, low);
        chk("clear_low", low, 37);
        repeat (2) @(negedge clk);
        check_pair("clear", 4'h0, 4'h1, 1'b0);
        clear_mon();

        // Back-to-back 'H' then 'i' with valid held.
        send(1'b1, 8'h48, 1'b0, low);
        req_data = 8'h69;
        gap = 0;
        while (req_ready && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        low2 = 0;
        while (!req_ready && low2 < 200) begin
            low2++;
            @(negedge clk);
        end
        chk("b2b_low1", low, 25);
        chk("b2b_gap", gap, 1);
        chk("b2b_low2", low2, 25);
        chk("b2b_npulse", rise_d.size(), 4);
        if (rise_d.size() == 4)
            chk("b2b_seq", {16'd0, rise_d[0], rise_d[1], rise_d[2], rise_d[3]}, 32'h4869);
        chk("b2b_stable", stab_err, 0);
        clear_mon();

        // Toggling valid while busy must not start another transfer.
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h55;
        @(posedge clk);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            req_valid = i[0];
            req_rs    = 1'b0;
            req_data  = 8'hA3 + 8'(i);
        end
        @(negedge clk);
        req_valid = 1'b0;
        low = 0;
        while (!req_ready && low < 200) begin
            low++;
            @(negedge clk);
        end
        repeat (30) @(negedge clk);
        check_pair("toggle", 4'h5, 4'h5, 1'b1);
        chk("toggle_ready", {31'd0, req_ready}, 32'd1);
        clear_mon();

        // Reset during E high of a character write.
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h7A;
        low = 0;
        while (!e && low < 100) begin
            low++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("abort_e_seen", {31'd0, e}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort_e_low", {31'd0, e}, 32'd0);
        chk("abort_flags", {29'd0, init_done, req_ready, busy}, 32'b001);
        @(negedge clk);
        clear_mon();
        first_rise = -1;
        rst = 1'b0;
        wait_init();
        chk("reinit_first_rise", first_rise, 102);
        repeat (40) @(negedge clk);
        check_init_pulses("reinit");
        chk("pins_const", pin_err, 0);
        chk("stable_all", stab_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
